// File: rtl/alarm_ring_pkg.sv
// Shared definitions for the alarm ring block: packed-BCD time field
// offsets, the separator nibble value, counter widths and FSM states.
package alarm_ring_pkg;

  localparam int SEC_ONES_LSB = 0;
  localparam int SEC_TENS_LSB = 4;
  localparam int SEP0_LSB     = 8;
  localparam int MIN_ONES_LSB = 12;
  localparam int MIN_TENS_LSB = 16;
  localparam int SEP1_LSB     = 20;
  localparam int HR_ONES_LSB  = 24;
  localparam int HR_TENS_LSB  = 28;

  localparam logic [3:0] BCD_SEP = 4'hE;

  localparam int RING_CNT_W = 17;
  localparam int SNZ_CNT_W  = 19;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_t;

  // Hours and minutes must agree and the seconds must read 00;
  // separator nibbles and the alarm's seconds field play no part.
  function automatic logic time_match(input logic [31:0] t, input logic [31:0] a);
    return (t[HR_TENS_LSB  +: 4] == a[HR_TENS_LSB  +: 4]) &&
           (t[HR_ONES_LSB  +: 4] == a[HR_ONES_LSB  +: 4]) &&
           (t[MIN_TENS_LSB +: 4] == a[MIN_TENS_LSB +: 4]) &&
           (t[MIN_ONES_LSB +: 4] == a[MIN_ONES_LSB +: 4]) &&
           (t[SEC_TENS_LSB +: 4] == 4'h0) &&
           (t[SEC_ONES_LSB +: 4] == 4'h0);
  endfunction

endpackage

// File: rtl/alarm_ring_btn_edge.sv
// Push-button conditioner: two-flop synchronizer into the clk_1khz domain
// followed by a rising-edge detector producing a one-cycle pulse.
module btn_edge (
  input  logic clk_1khz,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // Synchronize the raw level and keep its previous value for edge detection.
  always_ff @(posedge clk_1khz or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_pulse = r_sync2 & ~r_prev;

endmodule

// File: rtl/alarm_ring.sv
// Alarm clock ring controller: detects the start of the alarm minute,
// rings with a gated 500 Hz tone, supports snooze and stop buttons and
// auto-stops after a bounded ring time.
module alarm_ring
  import alarm_ring_pkg::*;
#(
  parameter int RING_MS   = 60000,
  parameter int SNOOZE_MS = 300000,
  parameter int BEEP_MS   = 500
) (
  input  logic        clk_1khz,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] time_in,
  input  logic [31:0] alarm_in,
  input  logic        alarm_on,
  input  logic        stop,
  input  logic        snooze,
  output logic        ringing,
  output logic        snoozing,
  output logic        buzzer
);

  localparam logic [RING_CNT_W-1:0] RING_LAST = RING_CNT_W'(RING_MS - 1);
  localparam logic [SNZ_CNT_W-1:0]  SNZ_LAST  = SNZ_CNT_W'(SNOOZE_MS - 1);
  localparam logic [RING_CNT_W-1:0] BEEP_W    = RING_CNT_W'(BEEP_MS);

  state_t                r_state;
  logic [RING_CNT_W-1:0] r_ring_cnt;
  logic [SNZ_CNT_W-1:0]  r_snz_cnt;
  logic                  r_tone;
  logic                  r_match_d;
  logic                  r_ringing;
  logic                  r_snoozing;
  logic                  r_buzzer;

  logic                  w_match;
  logic                  w_trigger;
  logic                  w_stop_pulse;
  logic                  w_snooze_pulse;
  logic [RING_CNT_W-1:0] w_ring_inc;
  logic [SNZ_CNT_W-1:0]  w_snz_inc;
  logic                  w_beep_inc;
  logic                  w_sep_unused;

  btn_edge u_stop_edge (
    .clk_1khz (clk_1khz),
    .rst_n    (rst_n),
    .i_btn    (stop),
    .o_pulse  (w_stop_pulse)
  );

  btn_edge u_snooze_edge (
    .clk_1khz (clk_1khz),
    .rst_n    (rst_n),
    .i_btn    (snooze),
    .o_pulse  (w_snooze_pulse)
  );

  // Separators and alarm seconds are carried on the bus but never compared.
  assign w_sep_unused = ^{time_in[SEP0_LSB +: 4] ^ BCD_SEP, time_in[SEP1_LSB +: 4],
                          alarm_in[SEP0_LSB +: 4], alarm_in[SEP1_LSB +: 4],
                          alarm_in[SEC_ONES_LSB +: 8]};

  assign w_match   = time_match(time_in, alarm_in);
  assign w_trigger = w_match & ~r_match_d & alarm_on & en;

  // Counters saturate instead of wrapping.
  assign w_ring_inc = (r_ring_cnt == {RING_CNT_W{1'b1}}) ? r_ring_cnt : r_ring_cnt + 17'd1;
  assign w_snz_inc  = (r_snz_cnt == {SNZ_CNT_W{1'b1}}) ? r_snz_cnt : r_snz_cnt + 19'd1;
  // Beep is on during even-numbered BEEP_MS windows of the ring counter.
  assign w_beep_inc = ((w_ring_inc / BEEP_W) & 17'd1) == 17'd0;

  // Delay match by one cycle; reset to 1 so a reset inside the alarm minute does not ring.
  always_ff @(posedge clk_1khz or negedge rst_n) begin
    if (!rst_n) begin
      r_match_d <= 1'b1;
    end else begin
      r_match_d <= w_match;
    end
  end

  // Ring FSM with counters and registered outputs updated alongside the state.
  always_ff @(posedge clk_1khz or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ring_cnt <= '0;
      r_snz_cnt  <= '0;
      r_tone     <= 1'b0;
      r_ringing  <= 1'b0;
      r_snoozing <= 1'b0;
      r_buzzer   <= 1'b0;
    end else if (!en) begin
      r_state    <= ST_IDLE;
      r_ring_cnt <= '0;
      r_snz_cnt  <= '0;
      r_tone     <= 1'b0;
      r_ringing  <= 1'b0;
      r_snoozing <= 1'b0;
      r_buzzer   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_snz_cnt  <= '0;
          r_ring_cnt <= '0;
          r_snoozing <= 1'b0;
          if (w_trigger) begin
            r_state   <= ST_RING;
            r_tone    <= 1'b1;
            r_ringing <= 1'b1;
            r_buzzer  <= 1'b1;
          end else begin
            r_state   <= ST_IDLE;
            r_tone    <= 1'b0;
            r_ringing <= 1'b0;
            r_buzzer  <= 1'b0;
          end
        end
        ST_RING: begin
          // Stop wins over snooze when both pulses arrive together.
          if (!alarm_on || w_stop_pulse || (r_ring_cnt == RING_LAST)) begin
            r_state    <= ST_IDLE;
            r_ring_cnt <= '0;
            r_snz_cnt  <= '0;
            r_tone     <= 1'b0;
            r_ringing  <= 1'b0;
            r_snoozing <= 1'b0;
            r_buzzer   <= 1'b0;
          end else if (w_snooze_pulse) begin
            r_state    <= ST_SNOOZE;
            r_ring_cnt <= '0;
            r_snz_cnt  <= '0;
            r_tone     <= 1'b0;
            r_ringing  <= 1'b0;
            r_snoozing <= 1'b1;
            r_buzzer   <= 1'b0;
          end else begin
            r_state    <= ST_RING;
            r_ring_cnt <= w_ring_inc;
            r_snz_cnt  <= '0;
            r_tone     <= ~r_tone;
            r_ringing  <= 1'b1;
            r_snoozing <= 1'b0;
            r_buzzer   <= w_beep_inc & ~r_tone;
          end
        end
        ST_SNOOZE: begin
          if (!alarm_on || w_stop_pulse) begin
            r_state    <= ST_IDLE;
            r_snz_cnt  <= '0;
            r_tone     <= 1'b0;
            r_ringing  <= 1'b0;
            r_snoozing <= 1'b0;
            r_buzzer   <= 1'b0;
          end else if (r_snz_cnt == SNZ_LAST) begin
            r_state    <= ST_RING;
            r_snz_cnt  <= '0;
            r_tone     <= 1'b1;
            r_ringing  <= 1'b1;
            r_snoozing <= 1'b0;
            r_buzzer   <= 1'b1;
          end else begin
            r_state    <= ST_SNOOZE;
            r_snz_cnt  <= w_snz_inc;
            r_tone     <= 1'b0;
            r_ringing  <= 1'b0;
            r_snoozing <= 1'b1;
            r_buzzer   <= 1'b0;
          end
          r_ring_cnt <= '0;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_ring_cnt <= '0;
          r_snz_cnt  <= '0;
          r_tone     <= 1'b0;
          r_ringing  <= 1'b0;
          r_snoozing <= 1'b0;
          r_buzzer   <= 1'b0;
        end
      endcase
    end
  end

  assign ringing  = r_ringing;
  assign snoozing = r_snoozing;
  assign buzzer   = r_buzzer;

endmodule

// File: tb/tb_alarm_ring.sv
// Self-checking bench for alarm_ring with shortened ring/snooze/beep times.
// Expected behaviour is derived from elapsed-cycle arithmetic on the
// ring and snooze timeline rather than from any internal state.
module tb_alarm_ring;

  localparam int RING_MS   = 40;
  localparam int SNOOZE_MS = 90;
  localparam int BEEP_MS   = 4;

  logic        clk_1khz = 1'b0;
  logic        rst_n    = 1'b0;
  logic        en       = 1'b0;
  logic [31:0] time_in  = 32'h0;
  logic [31:0] alarm_in = 32'h0;
  logic        alarm_on = 1'b0;
  logic        stop     = 1'b0;
  logic        snooze   = 1'b0;
  logic        ringing;
  logic        snoozing;
  logic        buzzer;

  int errors = 0;
  int checks = 0;
  int a_h;
  int a_m;

  alarm_ring #(
    .RING_MS   (RING_MS),
    .SNOOZE_MS (SNOOZE_MS),
    .BEEP_MS   (BEEP_MS)
  ) dut (
    .clk_1khz (clk_1khz),
    .rst_n    (rst_n),
    .en       (en),
    .time_in  (time_in),
    .alarm_in (alarm_in),
    .alarm_on (alarm_on),
    .stop     (stop),
    .snooze   (snooze),
    .ringing  (ringing),
    .snoozing (snoozing),
    .buzzer   (buzzer)
  );

  always #5 clk_1khz = ~clk_1khz;

  // Advance one clock; outputs are then sampled 2 time units after the edge.
  task automatic step();
    @(posedge clk_1khz);
    #2;
  endtask

  function automatic logic [7:0] bcd2(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  function automatic logic [31:0] mk(input int h, input int m, input int s);
    return {bcd2(h), 4'hE, bcd2(m), 4'hE, bcd2(s)};
  endfunction

  // Buzzer during ring cycle k: tone high on even cycles, beep high in even BEEP windows.
  function automatic logic exp_buzz(input int k);
    return (((k / BEEP_MS) % 2) == 0) && ((k % 2) == 0);
  endfunction

  task automatic new_alarm();
    a_h = $urandom_range(23, 0);
    a_m = $urandom_range(59, 0);
    alarm_in = mk(a_h, a_m, 0);
  endtask

  // Step into the alarm minute from its last-second-before and expect ringing.
  task automatic start_ring();
    time_in = mk(a_h, a_m, 59);
    step();
    time_in = mk(a_h, a_m, 0);
    step();
    checks++;
    if (ringing !== 1'b1) begin
      errors++;
      $display("FAIL start_ring: ringing=%b expected 1", ringing);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; alarm_on = 1'b1;
    new_alarm();
    time_in = alarm_in;
    step(); step();
    checks += 3;
    if (ringing !== 1'b0)  begin errors++; $display("FAIL reset_ringing: got %b expected 0", ringing); end
    if (snoozing !== 1'b0) begin errors++; $display("FAIL reset_snoozing: got %b expected 0", snoozing); end
    if (buzzer !== 1'b0)   begin errors++; $display("FAIL reset_buzzer: got %b expected 0", buzzer); end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (ringing !== 1'b0) begin
        errors++;
        $display("FAIL reset_release_match: ringing=%b expected 0 at cycle %0d", ringing, i);
      end
    end
  endtask

  task automatic test_ring();
    int k;
    for (int it = 0; it < 2; it++) begin
      new_alarm();
      start_ring();
      k = 0;
      while (ringing === 1'b1 && k < RING_MS + 10) begin
        checks++;
        if (buzzer !== exp_buzz(k)) begin
          errors++;
          $display("FAIL ring_buzzer: k=%0d buzzer=%b expected %b", k, buzzer, exp_buzz(k));
        end
        k++;
        step();
      end
      checks++;
      if (k != RING_MS) begin
        errors++;
        $display("FAIL ring_duration: rang %0d cycles expected %0d", k, RING_MS);
      end
      for (int i = 0; i < 20; i++) begin
        step();
        checks++;
        if (ringing !== 1'b0 || buzzer !== 1'b0) begin
          errors++;
          $display("FAIL no_rering: ringing=%b buzzer=%b expected 0/0", ringing, buzzer);
        end
      end
    end
  endtask

  task automatic test_snooze();
    int p;
    int n;
    new_alarm();
    start_ring();
    p = $urandom_range(RING_MS - 10, 3);
    repeat (p) step();
    snooze = 1'b1;
    step(); step();
    checks++;
    if (snoozing !== 1'b0 || ringing !== 1'b1) begin
      errors++;
      $display("FAIL snooze_latency_early: snoozing=%b ringing=%b expected 0/1", snoozing, ringing);
    end
    step();
    checks++;
    if (snoozing !== 1'b1 || ringing !== 1'b0 || buzzer !== 1'b0) begin
      errors++;
      $display("FAIL snooze_enter: snoozing=%b ringing=%b buzzer=%b expected 1/0/0", snoozing, ringing, buzzer);
    end
    snooze = 1'b0;
    n = 0;
    while (snoozing === 1'b1 && n < SNOOZE_MS + 10) begin
      n++;
      step();
    end
    checks++;
    if (n != SNOOZE_MS) begin
      errors++;
      $display("FAIL snooze_duration: snoozed %0d cycles expected %0d", n, SNOOZE_MS);
    end
    checks++;
    if (ringing !== 1'b1 || buzzer !== 1'b1) begin
      errors++;
      $display("FAIL snooze_rering: ringing=%b buzzer=%b expected 1/1", ringing, buzzer);
    end
    snooze = 1'b1;
    repeat (3) step();
    snooze = 1'b0;
    checks++;
    if (snoozing !== 1'b1) begin
      errors++;
      $display("FAIL snooze_second: snoozing=%b expected 1", snoozing);
    end
    repeat ($urandom_range(20, 1)) step();
    stop = 1'b1;
    step(); step();
    checks++;
    if (snoozing !== 1'b1) begin
      errors++;
      $display("FAIL stop_in_snooze_early: snoozing=%b expected 1", snoozing);
    end
    step();
    checks++;
    if (snoozing !== 1'b0 || ringing !== 1'b0) begin
      errors++;
      $display("FAIL stop_in_snooze: snoozing=%b ringing=%b expected 0/0", snoozing, ringing);
    end
    stop = 1'b0;
    step();
  endtask

  task automatic test_simultaneous();
    new_alarm();
    start_ring();
    repeat ($urandom_range(10, 2)) step();
    stop = 1'b1;
    snooze = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (ringing !== 1'b0 || snoozing !== 1'b0) begin
        errors++;
        $display("FAIL simultaneous: ringing=%b snoozing=%b expected 0/0", ringing, snoozing);
      end
      step();
    end
    stop = 1'b0;
    snooze = 1'b0;
    step();
  endtask

  task automatic test_alarm_off();
    new_alarm();
    alarm_on = 1'b0;
    time_in = mk(a_h, a_m, 59);
    step();
    time_in = mk(a_h, a_m, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (ringing !== 1'b0) begin
        errors++;
        $display("FAIL alarm_off_match: ringing=%b expected 0", ringing);
      end
    end
    alarm_on = 1'b1;
    start_ring();
    alarm_on = 1'b0;
    step();
    checks++;
    if (ringing !== 1'b0 || buzzer !== 1'b0) begin
      errors++;
      $display("FAIL alarm_off_ring: ringing=%b buzzer=%b expected 0/0", ringing, buzzer);
    end
    alarm_on = 1'b1;
    start_ring();
    snooze = 1'b1;
    repeat (3) step();
    snooze = 1'b0;
    alarm_on = 1'b0;
    step();
    checks++;
    if (snoozing !== 1'b0 || ringing !== 1'b0) begin
      errors++;
      $display("FAIL alarm_off_snooze: snoozing=%b ringing=%b expected 0/0", snoozing, ringing);
    end
    alarm_on = 1'b1;
    step();
  endtask

  task automatic test_en();
    new_alarm();
    start_ring();
    en = 1'b0;
    step();
    checks++;
    if (ringing !== 1'b0 || buzzer !== 1'b0 || snoozing !== 1'b0) begin
      errors++;
      $display("FAIL en_low_ring: ringing=%b buzzer=%b snoozing=%b expected 0/0/0", ringing, buzzer, snoozing);
    end
    time_in = mk(a_h, a_m, 59);
    step();
    time_in = mk(a_h, a_m, 0);
    step();
    en = 1'b1;
    step();
    checks++;
    if (ringing !== 1'b0) begin
      errors++;
      $display("FAIL en_low_trigger: ringing=%b expected 0", ringing);
    end
  endtask

  task automatic test_reset_midring();
    new_alarm();
    start_ring();
    checks++;
    if (buzzer !== 1'b1) begin
      errors++;
      $display("FAIL midring_buzzer_on: buzzer=%b expected 1", buzzer);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (ringing !== 1'b0 || buzzer !== 1'b0) begin
      errors++;
      $display("FAIL reset_midring_async: ringing=%b buzzer=%b expected 0/0", ringing, buzzer);
    end
    step();
    rst_n = 1'b1;
    step(); step();
    checks++;
    if (ringing !== 1'b0) begin
      errors++;
      $display("FAIL reset_midring_release: ringing=%b expected 0", ringing);
    end
  endtask

  initial begin
    test_reset();
    test_ring();
    test_snooze();
    test_simultaneous();
    test_alarm_off();
    test_en();
    test_reset_midring();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
